// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq
// Reset synchronizer and sequencer for the chip-level reset tree.
// The pad reset asserts every output immediately and asynchronously. Release
// is synchronous: after a synchronizer chain and a hold time, the outputs are
// released one at a time, bit 0 first, spaced STAGGER clocks apart. A software
// request re-runs the hold and release sequence without the pad reset.
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low pad reset
//   sw_rst_req  - synchronous, level-sensitive software reset request
//   rst_out_n   - N_OUT active-low sequenced reset outputs (bit 0 first)
//   rst_done    - high once every output has been released
//   rst_cause   - 0: last reset came from rst_n, 1: from sw_rst_req
// ---------------------------------------------------------------------------
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_out_n,
    output logic             rst_done,
    output logic             rst_cause
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state,   w_stateNext;
    logic [CW-1:0]          r_holdCnt, w_holdCntNext;
    logic [CW-1:0]          r_stgCnt,  w_stgCntNext;
    logic [IW-1:0]          r_idx,     w_idxNext;
    logic [N_OUT-1:0]       r_out,     w_outNext;
    logic                   r_done,    w_doneNext;
    logic                   r_cause,   w_causeNext;

    logic                   w_s;
    logic [CW-1:0]          w_holdInc;
    logic [CW-1:0]          w_stgInc;

    // Deassertion synchronizer: ones shift in only while rst_n is high, so the
    // release of the pad reset is seen a fixed number of clocks later and any
    // metastability on the first stage is resolved before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_holdInc = r_holdCnt + 1'b1;
    assign w_stgInc  = r_stgCnt + 1'b1;

    // State and sequencing registers; all of them clear straight to the
    // asserted-reset condition when the pad reset goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HOLD;
            r_holdCnt <= '0;
            r_stgCnt  <= '0;
            r_idx     <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_cause   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_holdCnt <= w_holdCntNext;
            r_stgCnt  <= w_stgCntNext;
            r_idx     <= w_idxNext;
            r_out     <= w_outNext;
            r_done    <= w_doneNext;
            r_cause   <= w_causeNext;
        end
    end

    // Next-state logic. A software request wins over the normal sequence in
    // every state, but only once the synchronized pad reset has cleared.
    // Counters are compared after incrementing so the release happens on the
    // edge where the count reaches its limit.
    always_comb begin
        w_stateNext   = r_state;
        w_holdCntNext = r_holdCnt;
        w_stgCntNext  = r_stgCnt;
        w_idxNext     = r_idx;
        w_outNext     = r_out;
        w_doneNext    = r_done;
        w_causeNext   = r_cause;

        if (w_s && sw_rst_req) begin
            w_outNext     = '0;
            w_doneNext    = 1'b0;
            w_causeNext   = 1'b1;
            w_stateNext   = ST_HOLD;
            w_holdCntNext = '0;
            w_stgCntNext  = '0;
            w_idxNext     = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_s) begin
                        if (w_holdInc == CW'(HOLD_CYCLES)) begin
                            w_outNext[0]  = 1'b1;
                            w_idxNext     = IW'(1);
                            w_stgCntNext  = '0;
                            w_holdCntNext = '0;
                            if (N_OUT == 1) begin
                                w_stateNext = ST_RUN;
                                w_doneNext  = 1'b1;
                            end else begin
                                w_stateNext = ST_RELEASE;
                            end
                        end else begin
                            w_holdCntNext = w_holdInc;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (w_stgInc == CW'(STAGGER)) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (IW'(k) == r_idx) begin
                                w_outNext[k] = 1'b1;
                            end
                        end
                        w_stgCntNext = '0;
                        w_idxNext    = r_idx + 1'b1;
                        if (r_idx == IW'(N_OUT - 1)) begin
                            w_stateNext = ST_RUN;
                            w_doneNext  = 1'b1;
                        end
                    end else begin
                        w_stgCntNext = w_stgInc;
                    end
                end
                ST_RUN: begin
                    w_outNext  = '1;
                    w_doneNext = 1'b1;
                end
                default: begin
                    w_stateNext = ST_HOLD;
                end
            endcase
        end
    end

    assign rst_out_n = r_out;
    assign rst_done  = r_done;
    assign rst_cause = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq
// Self-checking bench for rst_seq. Two instances share clock and pad reset:
// the default configuration and a short variant (SYNC_STAGES=3, HOLD_CYCLES=1,
// STAGGER=1, N_OUT=1). A timing model numbers clock edges since the pad reset
// released and records the edge from which the hold time starts; each output
// is expected high once enough edges have passed that start point.
// ---------------------------------------------------------------------------
module tb_rst_seq;

    localparam int SYNC = 2, HOLD = 4, STAG = 4, NOUT = 3;
    localparam int SYNC_V = 3, HOLD_V = 1, STAG_V = 1, NOUT_V = 1;

    logic       clk = 1'b0;
    logic       clkRun = 1'b1;
    logic       rst_n = 1'b0;
    logic       swReq = 1'b0;
    logic       swReqV = 1'b0;
    logic [2:0] outD;
    logic       doneD, causeD;
    logic [0:0] outV;
    logic       doneV, causeV;

    int nCompared = 0;
    int nMismatched = 0;

    // model state
    int n = 0;
    int t0 = SYNC;
    int t0V = SYNC_V;
    logic expCause = 1'b0;
    logic expCauseV = 1'b0;

    rst_seq #(.SYNC_STAGES(SYNC), .N_OUT(NOUT), .HOLD_CYCLES(HOLD), .STAGGER(STAG)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(swReq),
        .rst_out_n(outD), .rst_done(doneD), .rst_cause(causeD));

    rst_seq #(.SYNC_STAGES(SYNC_V), .N_OUT(NOUT_V), .HOLD_CYCLES(HOLD_V), .STAGGER(STAG_V)) dutV (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(swReqV),
        .rst_out_n(outV), .rst_done(doneV), .rst_cause(causeV));

    // Stoppable clock: it only toggles while clkRun is set.
    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    // Timing model. Edges are numbered from 1 after the pad reset releases.
    // A request counts only when the synchronized reset was already high
    // before the edge, i.e. from edge SYNC+1 onwards; it moves the start point.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            t0 = SYNC;
            t0V = SYNC_V;
            expCause = 1'b0;
            expCauseV = 1'b0;
        end else begin
            n = n + 1;
            if (swReq && n > SYNC) begin
                t0 = n;
                expCause = 1'b1;
            end
            if (swReqV && n > SYNC_V) begin
                t0V = n;
                expCauseV = 1'b1;
            end
        end
    end

    function automatic logic [2:0] expOut(int edgeNum, int start);
        logic [2:0] r;
        for (int k = 0; k < NOUT; k++) r[k] = (edgeNum >= start + HOLD + k * STAG);
        return r;
    endfunction

    function automatic logic expOutV(int edgeNum, int start);
        return (edgeNum >= start + HOLD_V);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic compareAll();
        logic [2:0] e;
        e = expOut(n, t0);
        checkOutput("out",    32'(outD),   32'(e));
        checkOutput("done",   32'(doneD),  32'(e[NOUT-1]));
        checkOutput("cause",  32'(causeD), 32'(expCause));
        checkOutput("outV",   32'(outV),   32'(expOutV(n, t0V)));
        checkOutput("doneV",  32'(doneV),  32'(expOutV(n, t0V)));
        checkOutput("causeV", 32'(causeV), 32'(expCauseV));
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge.
    task automatic applyStimulus(input logic sw, input logic swV);
        swReq = sw;
        swReqV = swV;
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic releaseSequence(input string tag);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (n == 3) checkOutput({tag, "_V_E3"}, 32'(outV), 32'd0);
            if (n == 4) checkOutput({tag, "_V_E4"}, 32'({doneV, outV}), 32'b11);
            if (n == 5) checkOutput({tag, "_E5"}, 32'(outD), 32'b000);
            if (n == 6) checkOutput({tag, "_E6"}, 32'(outD), 32'b001);
            if (n == 9) checkOutput({tag, "_E9"}, 32'(outD), 32'b001);
            if (n == 10) checkOutput({tag, "_E10"}, 32'(outD), 32'b011);
            if (n == 13) checkOutput({tag, "_E13"}, 32'({doneD, outD}), 32'b0011);
            if (n == 14) checkOutput({tag, "_E14"}, 32'({doneD, outD}), 32'b1111);
        end
    endtask

    initial begin
        int er;

        // Power-on: pad reset held for five clocks
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compareAll();
        end
        checkOutput("rstOut", 32'(outD), 32'd0);
        checkOutput("rstCause", 32'(causeD), 32'd0);
        #2 rst_n = 1'b1;
        releaseSequence("po");
        checkOutput("poCause", 32'(causeD), 32'd0);

        // Asynchronous assertion with the clock stopped
        clkRun = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        compareAll();
        checkOutput("asyncOut", 32'({doneD, outD}), 32'd0);
        checkOutput("asyncOutV", 32'({doneV, outV}), 32'd0);
        #3 rst_n = 1'b1;
        #2 clkRun = 1'b1;
        releaseSequence("async");

        // Single-cycle software request in RUN
        applyStimulus(1'b1, 1'b0);
        er = n;
        checkOutput("swAfterEr", 32'({doneD, outD}), 32'd0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (n == er + 3) checkOutput("swEr3", 32'(outD), 32'b000);
            if (n == er + 4) checkOutput("swEr4", 32'(outD), 32'b001);
            if (n == er + 8) checkOutput("swEr8", 32'(outD), 32'b011);
            if (n == er + 12) checkOutput("swEr12", 32'({doneD, outD}), 32'b1111);
        end
        checkOutput("swCause", 32'(causeD), 32'd1);

        // Request held for ten clocks
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("heldLow", 32'(outD), 32'd0);
        end
        er = n;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (n == er + 4) checkOutput("heldEr4", 32'(outD), 32'b001);
        end

        // Request arriving mid-release, one edge after bit 0 comes out
        applyStimulus(1'b1, 1'b0);
        er = n;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("midBefore", 32'(outD), 32'b001);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midReassert", 32'(outD), 32'b000);
        er = n;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (n == er + 4) checkOutput("midEr4", 32'(outD), 32'b001);
            if (n == er + 12) checkOutput("midEr12", 32'(outD), 32'b111);
        end

        // Random requests with occasional mid-cycle pad resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                compareAll();
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) applyStimulus(1'b1, 1'b1);
                #2 rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset synchronizer and sequencer for the chip-level reset tree. It takes the asynchronous board/pad reset and asserts every downstream reset output immediately. It then releases those outputs synchronously, in a fixed order, after a synchronizer delay and a minimum hold time. It also accepts a synchronous software reset request that re-runs the same hold and release sequence without the pad reset.

## Interface
- SYNC_STAGES, 2, number of flops in the deassertion synchronizer chain (legal ≥ 2)
- N_OUT, 3, number of sequenced reset outputs (legal ≥ 1)
- HOLD_CYCLES, 4, clock edges reset outputs stay asserted after the synchronized reset or software request clears (legal ≥ 1)
- STAGGER, 4, clock edges between successive output releases (legal ≥ 1)

- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset; one clock, reset asynchronous active-low
- sw_rst_req, input, 1, synchronous software reset request, sampled on rising clk; level-sensitive
- rst_out_n, output, N_OUT, active-low reset outputs; bit 0 released first
- rst_done, output, 1, high when all rst_out_n bits are released (state RUN)
- rst_cause, output, 1, 0 = last reset was rst_n, 1 = last reset was sw_rst_req

## Operation
- All flops are cleared asynchronously by rst_n low.
- Reset values:
  - sync chain = 0
  - state = HOLD, counters = 0
  - rst_out_n = all 0
  - rst_done = 0
  - rst_cause = 0
- Assertion is asynchronous: rst_out_n falls with rst_n, with no clock required. Deassertion is always synchronous to clk.
- Sync chain: SYNC_STAGES flops shift in 1 each edge while rst_n is high. s = last stage.
- FSM states:
  - HOLD:
    - While s = 0, hold_cnt stays 0.
    - While s = 1, hold_cnt increments each edge.
    - On the edge where the count reaches HOLD_CYCLES: rst_out_n[0] ← 1, idx ← 1, stg_cnt ← 0. Go to RELEASE, or go to RUN if N_OUT = 1.
  - RELEASE:
    - stg_cnt increments each edge.
    - On the edge where it reaches STAGGER: rst_out_n[idx] ← 1, stg_cnt ← 0, idx++.
    - After bit N_OUT-1 is released, go to RUN.
  - RUN: all outputs high, rst_done = 1.
- rst_done is registered and rises on the same edge as rst_out_n[N_OUT-1].
- Software request: sw_rst_req sampled high at any edge with s = 1, in any state, causes:
  - rst_out_n ← 0 (all bits), rst_done ← 0, rst_cause ← 1
  - state ← HOLD, hold_cnt ← 0, idx/stg_cnt ← 0
- Request held high: outputs stay asserted. Hold counting starts at the first edge after the last high sample.
- A request arriving mid-RELEASE re-asserts every output, including bits already released, and restarts the sequence.
- sw_rst_req is ignored while s = 0; the pad reset dominates.
- rst_cause keeps its value across a software sequence and is cleared only by rst_n.
- Counter widths: $clog2(max(HOLD_CYCLES, STAGGER)+1) for counts, $clog2(N_OUT+1) for idx. Counters never wrap.
- Reset mid-operation: rst_n low at any time, in any state, immediately returns everything to reset values.

## Timing
- E1 = first rising clk edge with rst_n high. s rises at E_SYNC_STAGES.
- rst_out_n[k] rises at edge E_(SYNC_STAGES + HOLD_CYCLES + k·STAGGER).
- rst_done rises with the last output, at E_(SYNC_STAGES + HOLD_CYCLES + (N_OUT-1)·STAGGER).
- Defaults: out[0] at E6, out[1] at E10, out[2] at E14, rst_done at E14.
- Software request last sampled high at edge Er:
  - all outputs low after Er
  - rst_out_n[k] rises at Er + HOLD_CYCLES + k·STAGGER
- Outputs change only on rising clk, except asynchronous assertion by rst_n.
- The rst_n deassertion edge may be arbitrarily close to a clk edge; the sync chain absorbs metastability.

## Test plan
- Power-on, defaults: rst_n low 5 cycles, released mid-cycle → out[0] at E6, out[1] at E10, out[2] at E14, rst_done at E14, rst_cause = 0.
- Async assert in RUN: drop rst_n between edges with clk stopped → rst_out_n = 3'b000 and rst_done = 0 immediately; resume → same E6/E10/E14 sequence.
- One-cycle sw_rst_req at Er in RUN → outputs 000 after Er; out[0] at Er+4, out[1] at Er+8, out[2] at Er+12; rst_cause = 1 until the next rst_n.
- sw_rst_req held 10 cycles, last high at Er → outputs stay 000 throughout; out[0] at Er+4.
- sw_rst_req at the edge after out[0] release, before out[1] → out[0] re-asserted; full sequence restarts from that edge.
- Variant SYNC_STAGES=3, HOLD_CYCLES=1, STAGGER=1, N_OUT=1 → rst_out_n[0] and rst_done both rise at E4.
